// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Microstep sequencer for an 8-bit accumulator CPU. It walks
//                T0..T4 per instruction, decodes the datapath control word
//                from state/opcode/flags, and supports free-run, single-step
//                and a reset-only HALT state.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  IRtoCU,
    input  logic        carry,
    input  logic        zero,
    input  logic        run_en,
    input  logic        step_req,
    output logic [15:0] ControlSignals,
    output logic        busy,
    output logic        instr_done,
    output logic        halted
);

    // Microstep states
    localparam logic [2:0] ST_T0   = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_T4   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    // Opcodes (IRtoCU[7:4])
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control words
    localparam logic [15:0] CW_NONE    = 16'h0000;
    localparam logic [15:0] CW_FETCH_A = 16'h0006;   // EP|LM
    localparam logic [15:0] CW_FETCH_B = 16'h0409;   // ER|CIR|CP
    localparam logic [15:0] CW_OPADDR  = 16'h0024;   // EIR|LM
    localparam logic [15:0] CW_LDA_RD  = 16'h0048;   // ER|LA
    localparam logic [15:0] CW_LD_B    = 16'h0808;   // ER|LB
    localparam logic [15:0] CW_ADD     = 16'h8240;   // FL|EU|LA
    localparam logic [15:0] CW_SUB     = 16'h8340;   // FL|EU|SU|LA
    localparam logic [15:0] CW_STA_WR  = 16'h0090;   // EA|WR
    localparam logic [15:0] CW_LDI     = 16'h0060;   // EIR|LA
    localparam logic [15:0] CW_JUMP    = 16'h2020;   // JP|EIR
    localparam logic [15:0] CW_OUT     = 16'h1080;   // LO|EA
    localparam logic [15:0] CW_HLT     = 16'h4000;   // HLT

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [15:0] ctrl;
    logic        in_instr;
    logic        last_step;
    logic [3:0]  opcode;
    logic        unused_operand;

    assign opcode = IRtoCU[7:4];
    // Operand nibble is consumed by the datapath, not by the sequencer.
    assign unused_operand = ^IRtoCU[3:0];

    // State register; reset abandons any instruction and returns to fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_T0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control-word decode.
    always_comb begin
        next_state = state;
        ctrl       = CW_NONE;
        in_instr   = 1'b0;
        last_step  = 1'b0;
        case (state)
            ST_T0: begin
                // A step request while free-running is indistinguishable
                // from run_en alone, so it is naturally ignored.
                if (run_en || step_req) begin
                    ctrl       = CW_FETCH_A;
                    next_state = ST_T1;
                end
            end
            ST_T1: begin
                in_instr   = 1'b1;
                ctrl       = CW_FETCH_B;
                next_state = ST_T2;
            end
            ST_T2: begin
                in_instr   = 1'b1;
                last_step  = 1'b1;
                next_state = ST_T0;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl       = CW_OPADDR;
                        last_step  = 1'b0;
                        next_state = ST_T3;
                    end
                    OP_LDI:  ctrl = CW_LDI;
                    OP_JMP:  ctrl = CW_JUMP;
                    OP_JC:   ctrl = carry ? CW_JUMP : CW_NONE;
                    OP_JZ:   ctrl = zero  ? CW_JUMP : CW_NONE;
                    OP_OUT:  ctrl = CW_OUT;
                    OP_HLT: begin
                        ctrl       = CW_HLT;
                        next_state = ST_HALT;
                    end
                    default: ctrl = CW_NONE;   // NOP and undefined opcodes
                endcase
            end
            ST_T3: begin
                in_instr   = 1'b1;
                last_step  = 1'b1;
                next_state = ST_T0;
                case (opcode)
                    OP_LDA:  ctrl = CW_LDA_RD;
                    OP_STA:  ctrl = CW_STA_WR;
                    OP_ADD, OP_SUB: begin
                        ctrl       = CW_LD_B;
                        last_step  = 1'b0;
                        next_state = ST_T4;
                    end
                    default: ctrl = CW_NONE;
                endcase
            end
            ST_T4: begin
                in_instr   = 1'b1;
                last_step  = 1'b1;
                next_state = ST_T0;
                ctrl       = (opcode == OP_SUB) ? CW_SUB : CW_ADD;
            end
            ST_HALT: begin
                ctrl       = CW_HLT;
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_T0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign ControlSignals = reset ? ctrl : CW_NONE;
    assign busy           = reset & in_instr;
    assign instr_done     = reset & last_step;
    assign halted         = reset & (state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer: opcode vector
//                table plus hand sequences for step, halt and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic [7:0]  IRtoCU;
    logic        carry;
    logic        zero;
    logic        run_en;
    logic        step_req;
    logic [15:0] ControlSignals;
    logic        busy;
    logic        instr_done;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Expected {ControlSignals, busy, instr_done, halted}
    logic [18:0] sb[$];

    typedef struct packed {
        logic [7:0]       ir;
        logic             c;
        logic             z;
        logic [2:0]       len;
        logic [4:0][15:0] w;
    } vec_t;

    vec_t vecs [14];

    control_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .IRtoCU         (IRtoCU),
        .carry          (carry),
        .zero           (zero),
        .run_en         (run_en),
        .step_req       (step_req),
        .ControlSignals (ControlSignals),
        .busy           (busy),
        .instr_done     (instr_done),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [7:0] ir, input logic c, input logic z,
                                input logic [2:0] len,
                                input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [15:0] w4);
        vec_t v;
        v.ir = ir; v.c = c; v.z = z; v.len = len;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        return v;
    endfunction

    task automatic push(input logic [15:0] cs, input logic b, input logic d, input logic h);
        sb.push_back({cs, b, d, h});
    endtask

    task automatic check_now(input string name);
        logic [18:0] exp;
        logic [18:0] act;
        act = {ControlSignals, busy, instr_done, halted};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, actual cs=%h b=%b d=%b h=%b",
                     name, act[18:3], act[2], act[1], act[0]);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: actual cs=%h b=%b d=%b h=%b, required cs=%h b=%b d=%b h=%b",
                         name, act[18:3], act[2], act[1], act[0],
                         exp[18:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    // Push one expectation and check it mid-cycle.
    task automatic expect1(input string name, input logic [15:0] cs,
                           input logic b, input logic d, input logic h);
        push(cs, b, d, h);
        #2;
        check_now(name);
    endtask

    initial begin
        vecs[0]  = mk(8'h5A, 0, 0, 3'd3, 16'h0006, 16'h0409, 16'h0060, 16'h0000, 16'h0000); // LDI
        vecs[1]  = mk(8'h1F, 0, 0, 3'd4, 16'h0006, 16'h0409, 16'h0024, 16'h0048, 16'h0000); // LDA
        vecs[2]  = mk(8'h2F, 0, 0, 3'd5, 16'h0006, 16'h0409, 16'h0024, 16'h0808, 16'h8240); // ADD
        vecs[3]  = mk(8'h3F, 0, 0, 3'd5, 16'h0006, 16'h0409, 16'h0024, 16'h0808, 16'h8340); // SUB
        vecs[4]  = mk(8'h4F, 0, 0, 3'd4, 16'h0006, 16'h0409, 16'h0024, 16'h0090, 16'h0000); // STA
        vecs[5]  = mk(8'h6F, 0, 0, 3'd3, 16'h0006, 16'h0409, 16'h2020, 16'h0000, 16'h0000); // JMP
        vecs[6]  = mk(8'h7C, 0, 1, 3'd3, 16'h0006, 16'h0409, 16'h0000, 16'h0000, 16'h0000); // JC nc
        vecs[7]  = mk(8'h7C, 1, 0, 3'd3, 16'h0006, 16'h0409, 16'h2020, 16'h0000, 16'h0000); // JC c
        vecs[8]  = mk(8'h8C, 1, 0, 3'd3, 16'h0006, 16'h0409, 16'h0000, 16'h0000, 16'h0000); // JZ nz
        vecs[9]  = mk(8'h8C, 0, 1, 3'd3, 16'h0006, 16'h0409, 16'h2020, 16'h0000, 16'h0000); // JZ z
        vecs[10] = mk(8'hE0, 0, 0, 3'd3, 16'h0006, 16'h0409, 16'h1080, 16'h0000, 16'h0000); // OUT
        vecs[11] = mk(8'h00, 0, 0, 3'd3, 16'h0006, 16'h0409, 16'h0000, 16'h0000, 16'h0000); // NOP
        vecs[12] = mk(8'h9F, 1, 1, 3'd3, 16'h0006, 16'h0409, 16'h0000, 16'h0000, 16'h0000); // undef
        vecs[13] = mk(8'hB3, 0, 0, 3'd3, 16'h0006, 16'h0409, 16'h0000, 16'h0000, 16'h0000); // undef

        reset = 1'b0; run_en = 1'b1; step_req = 1'b0;
        IRtoCU = 8'h5A; carry = 1'b0; zero = 1'b0;

        // Reset state, with run_en high.
        repeat (2) begin
            @(negedge clk);
            expect1("reset_hold", 16'h0000, 0, 0, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Table-driven free-running instructions, back to back.
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            IRtoCU = vecs[i].ir; carry = vecs[i].c; zero = vecs[i].z;
            run_en = 1'b1; step_req = 1'b0;
            for (int k = 0; k < int'(vecs[i].len); k++)
                push(vecs[i].w[k], k > 0, k == int'(vecs[i].len) - 1, 1'b0);
            #2;
            check_now($sformatf("vec%0d_ir%h_t0", i, vecs[i].ir));
            for (int k = 1; k < int'(vecs[i].len); k++) begin
                @(negedge clk);
                #2;
                check_now($sformatf("vec%0d_ir%h_t%0d", i, vecs[i].ir, k));
            end
        end

        // Pause: idle in T0.
        @(negedge clk); run_en = 1'b0; IRtoCU = 8'h1F;
        expect1("pause_idle0", 16'h0000, 0, 0, 0);
        @(negedge clk);
        expect1("pause_idle1", 16'h0000, 0, 0, 0);
        // Single step LDA; second step_req during T2 ignored.
        @(negedge clk); step_req = 1'b1;
        expect1("step_t0", 16'h0006, 0, 0, 0);
        @(negedge clk); step_req = 1'b0;
        expect1("step_t1", 16'h0409, 1, 0, 0);
        @(negedge clk); step_req = 1'b1;
        expect1("step_t2_req", 16'h0024, 1, 0, 0);
        @(negedge clk); step_req = 1'b0;
        expect1("step_t3", 16'h0048, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect1("step_hold", 16'h0000, 0, 0, 0);
        end

        // run_en dropped mid ADD: instruction completes, then pauses.
        @(negedge clk); run_en = 1'b1; IRtoCU = 8'h2F;
        expect1("drop_t0", 16'h0006, 0, 0, 0);
        @(negedge clk); run_en = 1'b0;
        expect1("drop_t1", 16'h0409, 1, 0, 0);
        @(negedge clk);
        expect1("drop_t2", 16'h0024, 1, 0, 0);
        @(negedge clk);
        expect1("drop_t3", 16'h0808, 1, 0, 0);
        @(negedge clk);
        expect1("drop_t4", 16'h8240, 1, 1, 0);
        @(negedge clk);
        expect1("drop_pause", 16'h0000, 0, 0, 0);

        // HLT, then persistence under toggling controls.
        @(negedge clk); run_en = 1'b1; IRtoCU = 8'hF0;
        expect1("hlt_t0", 16'h0006, 0, 0, 0);
        @(negedge clk);
        expect1("hlt_t1", 16'h0409, 1, 0, 0);
        @(negedge clk);
        expect1("hlt_t2", 16'h4000, 1, 1, 0);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            run_en = 1'($urandom_range(0, 1));
            step_req = 1'($urandom_range(0, 1));
            expect1("halt_hold", 16'h4000, 0, 0, 1);
        end
        // Asynchronous reset mid-cycle.
        @(negedge clk); run_en = 1'b1; step_req = 1'b0;
        #2; reset = 1'b0; #1;
        push(16'h0000, 0, 0, 0);
        check_now("halt_async_reset");
        @(negedge clk); IRtoCU = 8'h5A;
        expect1("halt_reset_hold", 16'h0000, 0, 0, 0);
        @(negedge clk); reset = 1'b1;
        expect1("post_halt_t0", 16'h0006, 0, 0, 0);
        @(negedge clk);
        expect1("post_halt_t1", 16'h0409, 1, 0, 0);
        @(negedge clk);
        expect1("post_halt_t2", 16'h0060, 1, 1, 0);

        // Reset during T3 of ADD.
        @(negedge clk); IRtoCU = 8'h2F;
        expect1("rst_add_t0", 16'h0006, 0, 0, 0);
        @(negedge clk);
        expect1("rst_add_t1", 16'h0409, 1, 0, 0);
        @(negedge clk);
        expect1("rst_add_t2", 16'h0024, 1, 0, 0);
        @(negedge clk);
        expect1("rst_add_t3", 16'h0808, 1, 0, 0);
        #1; reset = 1'b0; #1;
        push(16'h0000, 0, 0, 0);
        check_now("rst_add_async");
        @(negedge clk);
        expect1("rst_add_hold", 16'h0000, 0, 0, 0);
        @(negedge clk); reset = 1'b1;
        expect1("rst_add_refetch", 16'h0006, 0, 0, 0);
        @(negedge clk);
        expect1("rst_add_refetch_t1", 16'h0409, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
